// File: rtl/dbc_portsc_tracker.sv
`default_nettype none
// ============================================================================
// Module   : dbc_portsc_tracker
// Purpose  : DbC PORTSC status/change tracker. Debounces PHY connect, registers
//            CCS/PED/PR/PLS and keeps sticky W1C change bits for the port FSM.
// Revision : 1.0 - initial release
// ============================================================================
module dbc_portsc_tracker #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PLS_W           = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             DCE,
  input  logic             phy_connect,
  input  logic [PLS_W-1:0] phy_pls,
  input  logic             phy_reset_busy,
  input  logic             phy_config_err,
  input  logic             sw_wr,
  input  logic [3:0]       sw_w1c,
  input  logic             sw_ped_clr,
  output logic             CCS,
  output logic             PED,
  output logic             PR,
  output logic [PLS_W-1:0] PLS,
  output logic             CSC,
  output logic             PRC,
  output logic             PLC,
  output logic             CEC,
  output logic             port_event
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DISC = 2'd1,
    S_DEB  = 2'd2,
    S_CONN = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic             w_pr_nxt;
  logic             w_ped_set;
  logic             w_ped_clr;
  logic             w_ped_nxt;
  logic [3:0]       w_chg_set;   // {CEC,PLC,PRC,CSC}
  logic [3:0]       w_chg_cur;
  logic [3:0]       w_chg_clr;
  logic [3:0]       w_chg_nxt;
  logic             w_event;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pr_nxt    = 1'b0;
    w_ped_set   = 1'b0;
    w_ped_clr   = sw_wr & sw_ped_clr;
    w_chg_set   = 4'b0000;

    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_DISC;
        w_cnt_nxt   = '0;
      end
      S_DISC: begin
        if (phy_connect) begin
          w_state_nxt = S_DEB;
          w_cnt_nxt   = '0;
        end
      end
      S_DEB: begin
        if (!phy_connect) begin
          w_state_nxt = S_DISC;
          w_cnt_nxt   = '0;
        end else if (r_cnt == C_CNT_LAST) begin
          w_state_nxt  = S_CONN;
          w_cnt_nxt    = '0;
          w_chg_set[0] = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_CONN: begin
        if (phy_pls != PLS) begin
          w_chg_set[2] = 1'b1;
        end
        if (phy_config_err) begin
          w_chg_set[3] = 1'b1;
          w_ped_clr    = 1'b1;
        end
        if (!phy_connect) begin
          // Disconnect is immediate; any reset completion on this edge is lost
          w_state_nxt  = S_DISC;
          w_cnt_nxt    = '0;
          w_chg_set[0] = 1'b1;
          w_ped_clr    = 1'b1;
        end else begin
          w_pr_nxt = phy_reset_busy;
          if (!PR && phy_reset_busy) begin
            w_ped_clr = 1'b1;
          end
          if (PR && !phy_reset_busy) begin
            w_ped_set    = 1'b1;
            w_chg_set[1] = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Clears of PED dominate a same-edge enable; change-bit sets dominate W1C
  assign w_ped_nxt = w_ped_clr ? 1'b0 : (w_ped_set ? 1'b1 : PED);
  assign w_chg_cur = {CEC, PLC, PRC, CSC};
  assign w_chg_clr = sw_wr ? sw_w1c : 4'b0000;
  assign w_chg_nxt = (w_chg_cur & ~w_chg_clr) | w_chg_set;
  assign w_event   = |(w_chg_set & ~w_chg_cur);

  always_ff @(posedge clock) begin
    if (reset || !DCE) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      CCS        <= 1'b0;
      PED        <= 1'b0;
      PR         <= 1'b0;
      PLS        <= '0;
      CSC        <= 1'b0;
      PRC        <= 1'b0;
      PLC        <= 1'b0;
      CEC        <= 1'b0;
      port_event <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      CCS        <= (w_state_nxt == S_CONN);
      PED        <= w_ped_nxt;
      PR         <= w_pr_nxt;
      PLS        <= phy_pls;
      CSC        <= w_chg_nxt[0];
      PRC        <= w_chg_nxt[1];
      PLC        <= w_chg_nxt[2];
      CEC        <= w_chg_nxt[3];
      port_event <= w_event;
    end
  end

endmodule
`default_nettype wire
